// File: rtl/counter_pkg.sv
// Shared types and constants for the ring/Johnson sequence controller and its
// shift datapath.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

endpackage

// File: rtl/shift_counter_core.sv
// Shift register datapath: parallel load, or a one-position left rotate that
// wraps the MSB back in true (ring) or inverted (Johnson).
module shift_counter_core
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             mode,
  output logic [WIDTH-1:0] out
);

  logic wrap_bit;

  assign wrap_bit = (mode == MODE_JOHNSON) ? ~out[WIDTH-1] : out[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (load) begin
      out <= load_val;
    end else if (shift) begin
      out <= {out[WIDTH-2:0], wrap_bit};
    end
  end

endmodule

// File: rtl/ring_seq_ctrl.sv
// Sequence controller: captures a request, loads the shift core, runs a fixed
// number of shifts with pause/abort, and pulses done on completion.
module ring_seq_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] steps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   remaining, remaining_nxt;
  logic               mode_q;
  logic [WIDTH-1:0]   seed_q;
  logic [CNT_W-1:0]   steps_q;
  logic               capture;
  logic               load;
  logic               shift;
  logic [WIDTH-1:0]   load_val;
  logic               seed_ok;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  assign seed_ok = is_onehot(seed_q);

  // A bad ring seed falls back to the single-bit pattern 1.
  always_comb begin
    if (mode_q == MODE_JOHNSON) begin
      load_val = '0;
    end else if (seed_ok) begin
      load_val = seed_q;
    end else begin
      load_val = WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      mode_q    <= MODE_RING;
      seed_q    <= '0;
      steps_q   <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      if (capture) begin
        mode_q  <= mode;
        seed_q  <= seed;
        steps_q <= steps;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    capture       = 1'b0;
    load          = 1'b0;
    shift         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          load          = 1'b1;
          err           = (mode_q == MODE_RING) && !seed_ok;
          remaining_nxt = steps_q;
          state_nxt     = (steps_q != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        // Abort beats pause, and pause beats the final step.
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!pause) begin
          shift         = 1'b1;
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  shift_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .shift    (shift),
    .mode     (mode_q),
    .out      (out)
  );

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Directed bench for ring_seq_ctrl: ring/Johnson sequences, bad seed, pause,
// zero and maximum step counts, abort on the final step and asynchronous reset.
module tb_ring_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] steps;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             err;

  int checks;
  int failures;

  ring_seq_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .seed  (seed),
    .steps (steps),
    .pause (pause),
    .abort (abort),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a start request; returns at the falling edge of the first cycle
  // after the start edge (the LOAD cycle).
  task automatic do_start(input logic m, input logic [WIDTH-1:0] s, input logic [CNT_W-1:0] n);
    start = 1'b1;
    mode  = m;
    seed  = s;
    steps = n;
    @(negedge clk);
    start = 1'b0;
    seed  = 8'hA5;
    steps = 8'd7;
  endtask

  logic [7:0] jseq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                           8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    seed  = '0;
    steps = '0;
    pause = 1'b0;
    abort = 1'b0;

    #12;
    check_val("rst_out",  32'(out),  32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_done", 32'(done), 32'h0);
    check_val("rst_err",  32'(err),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'h0);

    // Johnson, 16 steps
    do_start(1'b1, 8'h00, 8'd16);
    check_val("j_load_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check_val("j_loaded", 32'(out), 32'h00);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_val($sformatf("j_out%0d", i), 32'(out), 32'(jseq[i]));
      check_val($sformatf("j_done%0d", i), 32'(done), (i == 15) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    check_val("j_after_done", 32'(done), 32'h0);
    check_val("j_after_busy", 32'(busy), 32'h0);

    // Ring, seed 0x10, 3 steps; a stray start mid-run is ignored
    do_start(1'b0, 8'h10, 8'd3);
    check_val("r_load_err", 32'(err), 32'h0);
    @(negedge clk);
    check_val("r_loaded", 32'(out), 32'h10);
    start = 1'b1;
    mode  = 1'b1;
    seed  = 8'h01;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
    check_val("r_out1", 32'(out), 32'h20);
    @(negedge clk);
    check_val("r_out2", 32'(out), 32'h40);
    check_val("r_nodone2", 32'(done), 32'h0);
    @(negedge clk);
    check_val("r_out3", 32'(out), 32'h80);
    check_val("r_done", 32'(done), 32'h1);
    @(negedge clk);
    check_val("r_post_done", 32'(done), 32'h0);
    check_val("r_post_busy", 32'(busy), 32'h0);
    check_val("r_post_out", 32'(out), 32'h80);

    // Ring, non-one-hot seed 0x11, 2 steps
    do_start(1'b0, 8'h11, 8'd2);
    check_val("bad_err", 32'(err), 32'h1);
    @(negedge clk);
    check_val("bad_err_clr", 32'(err), 32'h0);
    check_val("bad_loaded", 32'(out), 32'h01);
    @(negedge clk);
    check_val("bad_out1", 32'(out), 32'h02);
    @(negedge clk);
    check_val("bad_out2", 32'(out), 32'h04);
    check_val("bad_done", 32'(done), 32'h1);

    // Ring, seed 0x01, 4 steps, pause for 3 cycles after the 2nd shift
    @(negedge clk);
    do_start(1'b0, 8'h01, 8'd4);
    @(negedge clk);
    check_val("p_loaded", 32'(out), 32'h01);
    @(negedge clk);
    check_val("p_out1", 32'(out), 32'h02);
    @(negedge clk);
    check_val("p_out2", 32'(out), 32'h04);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("p_hold%0d", i), 32'(out), 32'h04);
      check_val($sformatf("p_hold_done%0d", i), 32'(done), 32'h0);
    end
    pause = 1'b0;
    @(negedge clk);
    check_val("p_out3", 32'(out), 32'h08);
    check_val("p_nodone3", 32'(done), 32'h0);
    @(negedge clk);
    check_val("p_out4", 32'(out), 32'h10);
    check_val("p_done", 32'(done), 32'h1);

    // steps = 0: LOAD then DONE
    @(negedge clk);
    do_start(1'b0, 8'h20, 8'd0);
    check_val("z_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check_val("z_out", 32'(out), 32'h20);
    check_val("z_done", 32'(done), 32'h1);
    check_val("z_busy_done", 32'(busy), 32'h0);
    @(negedge clk);
    check_val("z_done_clr", 32'(done), 32'h0);

    // Abort on the final step
    do_start(1'b0, 8'h01, 8'd2);
    @(negedge clk);
    check_val("a_loaded", 32'(out), 32'h01);
    @(negedge clk);
    check_val("a_out1", 32'(out), 32'h02);
    abort = 1'b1;
    @(negedge clk);
    check_val("a_hold", 32'(out), 32'h02);
    check_val("a_busy", 32'(busy), 32'h0);
    check_val("a_nodone", 32'(done), 32'h0);
    abort = 1'b0;
    @(negedge clk);
    check_val("a_nodone2", 32'(done), 32'h0);
    check_val("a_idle_out", 32'(out), 32'h02);

    // Maximum step count: 255 rotations of 0x01 leave 0x80
    do_start(1'b0, 8'h01, 8'd255);
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check_val("max_cycle", 32'(cyc), 32'd257);
    check_val("max_out", 32'(out), 32'h80);
    @(negedge clk);

    // Asynchronous reset in the middle of a Johnson run
    do_start(1'b1, 8'h00, 8'd10);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_val("rr_out_before", 32'(out), 32'h03);
    #2;
    rst = 1'b1;
    #1;
    check_val("rr_out", 32'(out), 32'h0);
    check_val("rr_busy", 32'(busy), 32'h0);
    check_val("rr_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rr_idle", 32'(busy), 32'h0);
    do_start(1'b0, 8'h04, 8'd1);
    @(negedge clk);
    check_val("rr_loaded", 32'(out), 32'h04);
    @(negedge clk);
    check_val("rr_out1", 32'(out), 32'h08);
    check_val("rr_fin_done", 32'(done), 32'h1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
